// File: rtl/alu_op_sequencer.sv
// Command FIFO and result-capture stage around an 8-bit combinational ALU.
// Head entry drives the ALU; results land in a handshaked slot with a sticky overflow flag.
module alu_op_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_a,
  input  logic [7:0]               cmd_b,
  input  logic [1:0]               cmd_op,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  output logic [1:0]               alu_op,
  input  logic [15:0]              alu_out,
  input  logic                     alu_overflow,
  input  logic                     alu_c_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [15:0]              res_data,
  output logic [1:0]               res_op,
  output logic                     res_overflow,
  output logic                     res_c_out,
  output logic [$clog2(DEPTH):0]   cmd_count,
  output logic                     ovf_sticky,
  input  logic                     sticky_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [17:0]   mem_q [DEPTH];
  logic [17:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          res_valid_q, res_valid_d;
  logic [15:0]   res_data_q, res_data_d;
  logic [1:0]    res_op_q, res_op_d;
  logic          res_overflow_q, res_overflow_d;
  logic          res_c_out_q, res_c_out_d;
  logic          sticky_q, sticky_d;
  logic          push_s, issue_s, empty_s;
  logic [17:0]   head_s;

  // cmd_ready looks only at registered occupancy, so it never waits on a same-cycle pop.
  assign empty_s   = (count_q == {CW{1'b0}});
  assign cmd_ready = (count_q < DEPTH_C) && !rst;
  assign push_s    = cmd_valid && cmd_ready;
  assign issue_s   = !empty_s && (!res_valid_q || res_ready);
  assign head_s    = mem_q[rd_ptr_q];

  always_comb begin
    if (empty_s) begin
      alu_a  = 8'h00;
      alu_b  = 8'h00;
      alu_op = 2'b00;
    end else begin
      alu_a  = head_s[17:10];
      alu_b  = head_s[9:2];
      alu_op = head_s[1:0];
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = {cmd_a, cmd_b, cmd_op};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (issue_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, issue_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Result slot: issue reloads it; a drain with nothing to issue only drops valid.
  always_comb begin
    res_valid_d    = res_valid_q;
    res_data_d     = res_data_q;
    res_op_d       = res_op_q;
    res_overflow_d = res_overflow_q;
    res_c_out_d    = res_c_out_q;
    if (issue_s) begin
      res_valid_d    = 1'b1;
      res_data_d     = alu_out;
      res_op_d       = head_s[1:0];
      res_overflow_d = alu_overflow;
      res_c_out_d    = alu_c_out;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
    if (issue_s && alu_overflow) begin
      sticky_d = 1'b1;
    end else if (sticky_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 18'd0;
      wr_ptr_q       <= {AW{1'b0}};
      rd_ptr_q       <= {AW{1'b0}};
      count_q        <= {CW{1'b0}};
      res_valid_q    <= 1'b0;
      res_data_q     <= 16'h0000;
      res_op_q       <= 2'b00;
      res_overflow_q <= 1'b0;
      res_c_out_q    <= 1'b0;
      sticky_q       <= 1'b0;
    end else begin
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      res_valid_q    <= res_valid_d;
      res_data_q     <= res_data_d;
      res_op_q       <= res_op_d;
      res_overflow_q <= res_overflow_d;
      res_c_out_q    <= res_c_out_d;
      sticky_q       <= sticky_d;
    end
  end

  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_op       = res_op_q;
  assign res_overflow = res_overflow_q;
  assign res_c_out    = res_c_out_q;
  assign cmd_count    = count_q;
  assign ovf_sticky   = sticky_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a combinational ALU stub.
module tb_alu_op_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [7:0]  cmd_a = 8'h00, cmd_b = 8'h00;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  alu_a, alu_b;
  logic [1:0]  alu_op;
  logic [15:0] alu_out;
  logic        alu_overflow, alu_c_out;
  logic        res_valid, res_ready = 1'b0;
  logic [15:0] res_data;
  logic [1:0]  res_op;
  logic        res_overflow, res_c_out;
  logic [2:0]  cmd_count;
  logic        ovf_sticky, sticky_clr = 1'b0;

  typedef logic [19:0] exp_t;
  exp_t exp_q[$];
  int n_cmp = 0, n_fail = 0, n_pop = 0, pop0 = 0;
  int streak = 0, max_streak = 0, max_count = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_c_out(alu_c_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_op(res_op), .res_overflow(res_overflow), .res_c_out(res_c_out),
    .cmd_count(cmd_count), .ovf_sticky(ovf_sticky), .sticky_clr(sticky_clr)
  );

  // ALU stub: {out, overflow, c_out}; overflow = b[7], c_out = a[6]
  function automatic logic [17:0] stub(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    logic [15:0] o;
    case (op)
      2'b00:   o = 16'(a) + 16'(b);
      2'b01:   o = 16'(a) - 16'(b);
      2'b10:   o = 16'(a) * 16'(b);
      default: o = {a, b};
    endcase
    return {o, b[7], a[6]};
  endfunction

  logic [17:0] stub_s;
  assign stub_s       = stub(alu_a, alu_b, alu_op);
  assign alu_out      = stub_s[17:2];
  assign alu_overflow = stub_s[1];
  assign alu_c_out    = stub_s[0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each accepted result
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (res_valid) streak++; else streak = 0;
      if (streak > max_streak) max_streak = streak;
      if (int'(cmd_count) > max_count) max_count = int'(cmd_count);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_result", {12'h000, res_data, res_op, res_overflow, res_c_out}, {12'h000, e});
          n_pop++;
        end
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    logic [17:0] r;
    bit done = 1'b0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        r = stub(a, b, op);
        exp_q.push_back({r[17:2], op, r[1:0]});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !res_valid) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk); #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_count", cmd_count, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_sticky", ovf_sticky, 0);
    rst = 1'b0; #1;
    chk("rel_cmd_ready", cmd_ready, 1);

    // single command
    res_ready = 1'b1;
    send(8'h5A, 8'h69, 2'b00);
    chk("single_alu_a", alu_a, 8'h5A);
    chk("single_alu_b", alu_b, 8'h69);
    chk("single_alu_op", alu_op, 2'b00);
    chk("single_count", cmd_count, 1);
    @(posedge clk); #1;
    chk("single_res_valid", res_valid, 1);
    chk("single_res_data", res_data, 16'h00C3);
    chk("single_res_c_out", res_c_out, 1);
    chk("single_res_ovf", res_overflow, 0);
    chk("single_res_op", res_op, 2'b00);
    drain();

    // backpressure fill
    res_ready = 1'b0;
    fork
      begin
        send(8'h11, 8'h22, 2'b00); send(8'h33, 8'h44, 2'b01);
        send(8'h55, 8'h66, 2'b10); send(8'h77, 8'h08, 2'b11);
        send(8'h99, 8'h2A, 2'b00); send(8'hBB, 8'h4C, 2'b01);
      end
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
          @(negedge clk);
          if (cmd_count == 3'd4) seen = 1'b1;
        end
        chk("bp_count", cmd_count, 4);
        chk("bp_cmd_ready", cmd_ready, 0);
        chk("bp_res_valid", res_valid, 1);
        chk("bp_res_data", res_data, 16'h0033);
        chk("bp_head", alu_a, 8'h33);
        repeat (3) @(negedge clk);
        chk("bp_hold_count", cmd_count, 4);
        chk("bp_hold_data", res_data, 16'h0033);
        @(posedge clk); #1;
        res_ready = 1'b1;
      end
    join
    drain();

    // streaming
    streak = 0; max_streak = 0; max_count = 0; pop0 = n_pop;
    for (int i = 0; i < 16; i++) send(8'(i * 13), 8'(8'hF0 - i), 2'(i));
    repeat (4) @(posedge clk); #1;
    chk("stream_streak", max_streak, 16);
    chk("stream_max_count_le1", (max_count <= 1), 1);
    chk("stream_pops", n_pop - pop0, 16);

    // sticky flag
    chk("sticky_after_stream", ovf_sticky, 1);
    sticky_clr = 1'b1; @(posedge clk); #1; sticky_clr = 1'b0;
    chk("sticky_clr", ovf_sticky, 0);
    send(8'h01, 8'h80, 2'b00);
    @(posedge clk); #1;
    chk("sticky_set", ovf_sticky, 1);
    chk("sticky_res_ovf", res_overflow, 1);
    sticky_clr = 1'b1; @(posedge clk); #1; sticky_clr = 1'b0;
    chk("sticky_clr2", ovf_sticky, 0);
    sticky_clr = 1'b1;
    send(8'h02, 8'h81, 2'b01);
    @(posedge clk); #1;
    chk("sticky_set_wins", ovf_sticky, 1);
    @(posedge clk); #1;
    chk("sticky_clr_after", ovf_sticky, 0);
    sticky_clr = 1'b0;
    drain();

    // reset mid-operation
    res_ready = 1'b0;
    send(8'hFF, 8'hFF, 2'b11); send(8'h10, 8'h20, 2'b00);
    send(8'h30, 8'h40, 2'b01); send(8'h50, 8'h60, 2'b10);
    @(negedge clk);
    chk("mid_count", cmd_count, 3);
    chk("mid_res_valid", res_valid, 1);
    chk("mid_sticky", ovf_sticky, 1);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("arst_cmd_ready", cmd_ready, 0);
    chk("arst_count", cmd_count, 0);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_res_fields", {res_data, res_op, res_overflow, res_c_out}, 0);
    chk("arst_alu", {alu_a, alu_b, alu_op}, 0);
    chk("arst_sticky", ovf_sticky, 0);
    exp_q.delete();
    rst = 1'b0; #1;
    chk("arel_cmd_ready", cmd_ready, 1);
    res_ready = 1'b1;
    send(8'h5A, 8'h69, 2'b00);
    chk("arel_no_stale", res_valid, 0);
    @(posedge clk); #1;
    chk("arel_res_valid", res_valid, 1);
    chk("arel_res_data", res_data, 16'h00C3);
    repeat (3) @(posedge clk); #1;
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command buffer and result capture stage wrapped around the 8-bit combinational ALU. Accepts operand/opcode commands over a valid/ready handshake, queues them in a small FIFO, and presents the head entry to the ALU's a/b/op_code inputs. It registers the ALU's out/overflow/c_out into a result slot with its own valid/ready handshake. It also keeps a sticky overflow flag for software polling.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command slot available
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- cmd_op  in  2  opcode, passed to ALU unmodified
- alu_a  out  8  to ALU a
- alu_b  out  8  to ALU b
- alu_op  out  2  to ALU op_code
- alu_out  in  16  from ALU out
- alu_overflow  in  1  from ALU overflow
- alu_c_out  in  1  from ALU c_out
- res_valid  out  1  result slot full
- res_ready  in  1  consumer accepts result
- res_data  out  16  captured alu_out
- res_op  out  2  opcode that produced res_data
- res_overflow  out  1  captured alu_overflow
- res_c_out  out  1  captured alu_c_out
- cmd_count  out  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- ovf_sticky  out  1  set by any captured overflow
- sticky_clr  in  1  synchronous clear of ovf_sticky

## Operation
- Push: cmd_valid && cmd_ready at a rising edge writes {cmd_a, cmd_b, cmd_op} at the write pointer. Pointers wrap modulo DEPTH.
- cmd_ready = (cmd_count < DEPTH) && !rst. It depends only on registered occupancy, never on the same-cycle pop.
- Head drive: when FIFO is non-empty, alu_a/alu_b/alu_op = head entry. When empty, all three are 0.
- Issue condition: FIFO non-empty && (!res_valid || res_ready).
- On issue at an edge:
  - Pop the head.
  - Load res_data←alu_out, res_overflow←alu_overflow, res_c_out←alu_c_out, res_op←head opcode.
  - Set res_valid.
- Drain without issue: res_valid && res_ready && FIFO empty clears res_valid. Result fields hold their last values.
- Stall: res_valid && !res_ready keeps the result slot, FIFO head and ALU drive unchanged.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance. This is legal at any occupancy where cmd_ready=1.
- Full FIFO: cmd_ready=0. A push attempt is ignored and FIFO contents are unchanged.
- ovf_sticky:
  - Set on any issue edge where alu_overflow=1.
  - Cleared by sticky_clr when no overflow is captured on that edge.
  - If set and clear happen on the same edge, set wins.
- No per-opcode arithmetic is performed here. All widths pass through unchanged, and res_data is always the full 16 bits.

## Timing
- Reset (async assert, any cycle, including mid-stream) takes effect immediately:
  - FIFO is emptied and pointers are zeroed.
  - cmd_count=0, cmd_ready=0, res_valid=0, res_data=0, res_op=0, res_overflow=0, res_c_out=0.
  - alu_a/alu_b/alu_op=0, ovf_sticky=0.
  - In-flight commands and the held result are discarded.
- After rst deasserts, cmd_ready=1 in the same cycle.
- Latency: a command accepted at edge k is presented on alu_* after edge k. It is captured with res_valid=1 after edge k+1, provided the slot is free or drained at k+1.
- Throughput: one result per cycle with cmd_valid and res_ready both held high. FIFO occupancy then stays at ≤1.
- ALU path: alu_* → ALU → alu_out must settle within one clk period. The path runs from FIFO registers to the result registers and has no extra pipeline stage.
- The res_* fields are stable while res_valid && !res_ready.

## Test plan
- Single command: the bench ALU stub returns alu_out=16'h00C3 with overflow=0 and c_out=1 for a=8'h5A, b=8'h69, op=2'b00. Push that command at edge 1, with res_ready=1.
  - Required: alu_a=8'h5A, alu_b=8'h69, alu_op=0 after edge 1.
  - Required: res_valid=1, res_data=16'h00C3, res_c_out=1, res_op=0 after edge 2.
- Backpressure fill: hold res_ready=0 and push 6 commands with DEPTH=4.
  - Required: the first command is captured in the result slot, and the FIFO then holds 4 more.
  - Required: cmd_ready=0 and cmd_count=4. The 6th command is not accepted until res_ready rises.
  - Required: results then emerge in push order.
- Streaming: push 16 commands back-to-back with res_ready=1.
  - Required: 16 consecutive res_valid cycles in order, starting 2 edges after the first push.
  - Required: cmd_count never exceeds 1 and no data is lost or duplicated across pointer wrap.
- Sticky flag:
  - A result with alu_overflow=1 sets ovf_sticky.
  - sticky_clr on a later edge with no overflow clears it.
  - sticky_clr coincident with an overflow capture leaves it at 1.
- Reset mid-operation: with 3 entries queued and res_valid=1 held, pulse rst asynchronously between edges.
  - Required: all outputs go to their reset values before the next edge.
  - Required: after release, the first new command produces a result two edges later, with no stale result present.
